// File: rtl/shift_mem_responder.sv
// shift_mem_responder: write-first word memory with a fixed-latency snapshot read pipeline.
// Optional feature: define RESP_STATUS_CNT_EN to add saturating wr_count/rd_count outputs.
module shift_mem_responder #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 4,
   parameter int READ_LAT  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_wr_en_in,
   input  logic                 mem_rd_en_in,
   input  logic [ADDRWIDTH-1:0] mem_addr_in,
   input  logic [DATAWIDTH-1:0] mem_data_in,
   output logic [DATAWIDTH-1:0] dataout,
   output logic                 DataValid,
`ifdef RESP_STATUS_CNT_EN
   output logic [15:0]          wr_count,
   output logic [15:0]          rd_count,
`endif
   output logic                 rd_uninit
);
   localparam int DEPTH = 2 ** ADDRWIDTH;

   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]     written_q;
   logic [READ_LAT-1:0]  vld_q;
   logic [READ_LAT-1:0]  un_q;
   logic [DATAWIDTH-1:0] dat_q [READ_LAT];
   logic [DATAWIDTH-1:0] cap_data_d;
   logic                 cap_un_d;

   // Snapshot for a read this cycle: a same-cycle write wins, never-written entries read as zero.
   always_comb begin
      cap_un_d   = !mem_wr_en_in && !written_q[mem_addr_in];
      cap_data_d = mem_wr_en_in ? mem_data_in : (cap_un_d ? '0 : mem_q[mem_addr_in]);
   end

   // Array storage; contents survive reset, but a write on a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (!reset && mem_wr_en_in) mem_q[mem_addr_in] <= mem_data_in;
   end

   // Per-entry written flags, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) written_q <= '0;
      else if (mem_wr_en_in) written_q[mem_addr_in] <= 1'b1;
   end

   // Read pipeline; payload only advances with a valid token so the last stage holds the last result.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         un_q  <= '0;
         for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= mem_rd_en_in;
         if (mem_rd_en_in) begin
            dat_q[0] <= cap_data_d;
            un_q[0]  <= cap_un_d;
         end
         for (int i = 1; i < READ_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
               un_q[i]  <= un_q[i-1];
            end
         end
      end
   end

   assign DataValid = vld_q[READ_LAT-1];
   assign dataout   = dat_q[READ_LAT-1];
   assign rd_uninit = vld_q[READ_LAT-1] && un_q[READ_LAT-1];

`ifdef RESP_STATUS_CNT_EN
   logic [15:0] wr_cnt_q;
   logic [15:0] rd_cnt_q;

   // Saturating counters of accepted writes and delivered read responses.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (mem_wr_en_in && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (DataValid && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

   assign wr_count = wr_cnt_q;
   assign rd_count = rd_cnt_q;
`endif
endmodule

// File: tb/tb_shift_mem_responder.sv
// tb_shift_mem_responder: directed checks of shift_mem_responder with READ_LAT=2.
module tb_shift_mem_responder;
   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] dataout;
   logic          dv;
   logic          un;
`ifdef RESP_STATUS_CNT_EN
   logic [15:0]   wr_count;
   logic [15:0]   rd_count;
`endif
   int total = 0;
   int bad = 0;

   shift_mem_responder #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .READ_LAT(LAT)) dut (
      .clk(clk),
      .reset(reset),
      .mem_wr_en_in(wr),
      .mem_rd_en_in(rd),
      .mem_addr_in(addr),
      .mem_data_in(wdata),
      .dataout(dataout),
      .DataValid(dv),
`ifdef RESP_STATUS_CNT_EN
      .wr_count(wr_count),
      .rd_count(rd_count),
`endif
      .rd_uninit(un)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr = 1'b1;
      addr = a;
      wdata = d;
      step();
      wr = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                           input logic exp_u, input logic also_wr, input logic [DW-1:0] wd);
      rd = 1'b1;
      wr = also_wr;
      addr = a;
      wdata = wd;
      step();
      rd = 1'b0;
      wr = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         check({tag, "_early_dv"}, 32'(dv), 32'd0);
         step();
      end
      check({tag, "_dv"}, 32'(dv), 32'd1);
      check({tag, "_data"}, 32'(dataout), 32'(exp_d));
      check({tag, "_uninit"}, 32'(un), 32'(exp_u));
      step();
      check({tag, "_dv_drop"}, 32'(dv), 32'd0);
      check({tag, "_uninit_drop"}, 32'(un), 32'd0);
      check({tag, "_hold"}, 32'(dataout), 32'(exp_d));
   endtask

   initial begin
      logic [DW-1:0] pre [4];
      pre[0] = 8'h11;
      pre[1] = 8'h22;
      pre[2] = 8'h33;
      pre[3] = 8'h44;
      step();
      step();
      reset = 1'b0;
      check("rst_dv", 32'(dv), 32'd0);
      check("rst_data", 32'(dataout), 32'd0);
      check("rst_uninit", 32'(un), 32'd0);
      read_chk("uninit3", 4'd3, 8'h00, 1'b1, 1'b0, 8'h00);
      wr_word(4'd5, 8'hA5);
      read_chk("rd5", 4'd5, 8'hA5, 1'b0, 1'b0, 8'h00);
      read_chk("rw7", 4'd7, 8'h3C, 1'b0, 1'b1, 8'h3C);
      rd = 1'b1;
      addr = 4'd7;
      step();
      rd = 1'b0;
      wr = 1'b1;
      wdata = 8'h99;
      step();
      wr = 1'b0;
      check("snap_dv", 32'(dv), 32'd1);
      check("snap_data", 32'(dataout), 32'h3C);
      step();
      read_chk("after_snap", 4'd7, 8'h99, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) wr_word(AW'(i), pre[i]);
      for (int i = 0; i < 6; i++) begin
         rd = (i < 4);
         addr = AW'(i);
         step();
         if (i >= 1 && i <= 4) begin
            check($sformatf("b2b%0d_dv", i - 1), 32'(dv), 32'd1);
            check($sformatf("b2b%0d_data", i - 1), 32'(dataout), 32'(pre[i-1]));
         end
         if (i == 5) begin
            check("b2b_end_dv", 32'(dv), 32'd0);
            check("b2b_end_hold", 32'(dataout), 32'h44);
         end
      end
      rd = 1'b0;
      rd = 1'b1;
      addr = 4'd5;
      step();
      rd = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_data", 32'(dataout), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("midrst_dv%0d", i), 32'(dv), 32'd0);
         step();
      end
      read_chk("post_rst5", 4'd5, 8'h00, 1'b1, 1'b0, 8'h00);
      reset = 1'b1;
      wr = 1'b1;
      addr = 4'd9;
      wdata = 8'h55;
      step();
      reset = 1'b0;
      wr = 1'b0;
      read_chk("rstwr9", 4'd9, 8'h00, 1'b1, 1'b0, 8'h00);
`ifdef RESP_STATUS_CNT_EN
      check("cnt_rstwr_wr", 32'(wr_count), 32'd0);
      check("cnt_rstwr_rd", 32'(rd_count), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("cnt_rst_wr", 32'(wr_count), 32'd0);
      check("cnt_rst_rd", 32'(rd_count), 32'd0);
      wr_word(4'd1, 8'h01);
      wr_word(4'd2, 8'h02);
      wr_word(4'd9, 8'h09);
      read_chk("cnt_rd1", 4'd1, 8'h01, 1'b0, 1'b0, 8'h00);
      read_chk("cnt_rd9", 4'd9, 8'h09, 1'b0, 1'b0, 8'h00);
      check("cnt_wr3", 32'(wr_count), 32'd3);
      check("cnt_rd2", 32'(rd_count), 32'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("cnt_clr_wr", 32'(wr_count), 32'd0);
      check("cnt_clr_rd", 32'(rd_count), 32'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
